dma_controller: RTL and testbench

//  Bus-master DMA engine on the far side of the external device port. On a CPU command it

---
 rtl/dma_controller.sv | 192 +++++++++++++++++++
 tb/tb_dma_controller.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_controller.sv
//------------------------------------------------------------------------------
// dma_controller
//
// Bus-master DMA engine. On a CPU command it requests the memory bus
// (o_br / i_bg) and walks the external device line by line through o_offset.
// Each 64-bit device line (LINE_WORDS x WORD_SIZE) is written to memory at
// consecutive line-aligned word addresses starting at the command base
// address. A one-cycle o_dma_end pulse interrupts the CPU when the transfer
// finishes.
//
// Configuration macro:
//   DMA_CYCLE_STEAL_EN  defined   -> after every acked line except the last,
//                                   br drops for one cycle so the CPU can
//                                   take the bus between lines.
//                       undefined -> burst mode, br held from REQ to DONE.
//
// Ports:
//   i_clk        rising-edge clock
//   i_reset      synchronous, active-high reset
//   i_cmd_valid  1-cycle command strobe (ignored while o_busy=1)
//   i_cmd_addr   memory base word address
//   i_cmd_len    transfer length in words
//   o_busy       high from accepted command through the o_dma_end cycle
//   o_br         bus request to CPU
//   i_bg         bus grant from CPU
//   o_offset     line index presented to the device
//   i_dev_data   device line at o_offset (combinational in the device)
//   o_mem_write  memory write request, held until i_mem_ack
//   o_mem_addr   write address, high-impedance when o_mem_write=0
//   o_mem_data   write data, high-impedance when o_mem_write=0
//   i_mem_ack    one-cycle write acknowledge
//   o_dma_end    one-cycle completion pulse
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module dma_controller #(
    parameter int WORD_SIZE      = 16,
    parameter int LINE_WORDS     = 4,
    parameter int NUM_LINES      = 3,
    parameter int DEVICE_BIT_LEN = 2
) (
    input  logic                            i_clk,
    input  logic                            i_reset,
    input  logic                            i_cmd_valid,
    input  logic [WORD_SIZE-1:0]            i_cmd_addr,
    input  logic [WORD_SIZE-1:0]            i_cmd_len,
    output logic                            o_busy,
    output logic                            o_br,
    input  logic                            i_bg,
    output logic [DEVICE_BIT_LEN-1:0]       o_offset,
    input  logic [LINE_WORDS*WORD_SIZE-1:0] i_dev_data,
    output logic                            o_mem_write,
    output logic [WORD_SIZE-1:0]            o_mem_addr,
    output logic [LINE_WORDS*WORD_SIZE-1:0] o_mem_data,
    input  logic                            i_mem_ack,
    output logic                            o_dma_end
);

    localparam int LINE_W = LINE_WORDS * WORD_SIZE;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_FETCH,
        ST_WRITE,
        ST_GAP,
        ST_DONE
    } state_t;

    state_t                r_state;
    state_t                w_next;

    logic                  r_busy;
    logic                  r_dma_end;
    logic [WORD_SIZE-1:0]  r_idx;
    logic [WORD_SIZE-1:0]  r_lines;
    logic [WORD_SIZE-1:0]  r_addr;
    logic [LINE_W-1:0]     r_data;

    logic                  w_accept;
    logic [WORD_SIZE-1:0]  w_quot;
    logic                  w_rem_nz;
    logic [WORD_SIZE-1:0]  w_ceil;
    logic [WORD_SIZE-1:0]  w_lines;
    logic                  w_last_line;

    // Line count: ceil(len / LINE_WORDS) built from quotient plus a
    // remainder flag, so len=16'hFFFF cannot overflow before the clamp.
    assign w_quot   = i_cmd_len / WORD_SIZE'(LINE_WORDS);
    assign w_rem_nz = (i_cmd_len % WORD_SIZE'(LINE_WORDS)) != '0;
    assign w_ceil   = w_quot + {{(WORD_SIZE-1){1'b0}}, w_rem_nz};
    assign w_lines  = (w_ceil > WORD_SIZE'(NUM_LINES)) ? WORD_SIZE'(NUM_LINES) : w_ceil;

    // Busy stays high through the dma_end cycle, which also covers the
    // DONE cycle, so a command arriving then is dropped.
    assign w_accept    = i_cmd_valid && !r_busy && (r_state == ST_IDLE);
    assign w_last_line = (r_idx + WORD_SIZE'(1)) == r_lines;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // NOTE: w_next gets its default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next = (w_lines == '0) ? ST_DONE : ST_REQ;
                end
            end
            ST_REQ: begin
                if (i_bg) begin
                    w_next = ST_FETCH;
                end
            end
            ST_FETCH: begin
                // One settle cycle with the offset driven; losing the grant
                // sends us back to arbitration for the same line.
                w_next = i_bg ? ST_WRITE : ST_REQ;
            end
            ST_WRITE: begin
                // An ack commits the line even if the grant drops in the
                // same cycle; otherwise a dropped grant retries the line.
                if (i_mem_ack) begin
                    if (w_last_line) begin
                        w_next = ST_DONE;
                    end else begin
`ifdef DMA_CYCLE_STEAL_EN
                        w_next = ST_GAP;
`else
                        w_next = ST_FETCH;
`endif
                    end
                end else if (!i_bg) begin
                    w_next = ST_REQ;
                end
            end
            ST_GAP:  w_next = ST_REQ;
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_busy    <= 1'b0;
            r_dma_end <= 1'b0;
            r_idx     <= '0;
            r_lines   <= '0;
            r_addr    <= '0;
        end else begin
            r_dma_end <= (r_state == ST_DONE);
            if (w_accept) begin
                r_busy  <= 1'b1;
                r_idx   <= '0;
                r_lines <= w_lines;
                r_addr  <= i_cmd_addr;
            end else if (r_dma_end) begin
                r_busy <= 1'b0;
            end
            if (r_state == ST_WRITE && i_mem_ack) begin
                r_idx  <= r_idx + WORD_SIZE'(1);
                r_addr <= r_addr + WORD_SIZE'(LINE_WORDS);
            end
        end
    end

    // NOTE: the line buffer carries no reset; it is only observed while
    // mem_write is high, and that always follows a capture.
    always_ff @(posedge i_clk) begin
        if (r_state == ST_FETCH && i_bg) begin
            r_data <= i_dev_data;
        end
    end

    assign o_busy      = r_busy;
    assign o_dma_end   = r_dma_end;
    assign o_br        = (r_state == ST_REQ) || (r_state == ST_FETCH) || (r_state == ST_WRITE);
    assign o_offset    = (r_state == ST_FETCH) ? r_idx[DEVICE_BIT_LEN-1:0] : '0;
    assign o_mem_write = (r_state == ST_WRITE);
    assign o_mem_addr  = o_mem_write ? r_addr : 'z;
    assign o_mem_data  = o_mem_write ? r_data : 'z;

endmodule

// File: tb/tb_dma_controller.sv
`timescale 1ns/1ps

module tb_dma_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic [15:0] cmd_addr;
    logic [15:0] cmd_len;
    logic        bg;
    logic [63:0] dev_data;
    logic        mem_ack;
    wire         busy;
    wire         br;
    wire  [1:0]  offset;
    wire         mem_write;
    wire  [15:0] mem_addr;
    wire  [63:0] mem_data;
    wire         dma_end;

    dma_controller dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_cmd_valid (cmd_valid),
        .i_cmd_addr  (cmd_addr),
        .i_cmd_len   (cmd_len),
        .o_busy      (busy),
        .o_br        (br),
        .i_bg        (bg),
        .o_offset    (offset),
        .i_dev_data  (dev_data),
        .o_mem_write (mem_write),
        .o_mem_addr  (mem_addr),
        .o_mem_data  (mem_data),
        .i_mem_ack   (mem_ack),
        .o_dma_end   (dma_end)
    );

    always #5 clk = ~clk;

    // Device storage, read combinationally through offset.
    logic [63:0] storage [3];
    initial begin
        storage[0] = 64'h1111_2222_3333_4444;
        storage[1] = 64'hAAAA_BBBB_CCCC_DDDD;
        storage[2] = 64'h0123_4567_89AB_CDEF;
    end
    always_comb begin
        dev_data = '0;
        if (offset < 2'd3) dev_data = storage[offset];
    end

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [15:0] addr;
        logic [63:0] data;
    } wr_t;
    wr_t exp_q[$];

    task automatic push_expected(input logic [15:0] base, input int nlines);
        for (int i = 0; i < nlines; i++) begin
            wr_t w;
            w.addr = base + 16'(4 * i);
            w.data = storage[i];
            exp_q.push_back(w);
        end
    endtask

    // Cycle stamps and event counters.
    int cyc         = 0;
    int n_writes    = 0;
    int n_end       = 0;
    int n_br_rise   = 0;
    int end_cyc     = -1;
    int cmd_cyc     = -1;
    int br_rise_cyc = -1;
    int bg_rise_cyc = -1;
    int mw_first    = -1;
    int mw_second   = -1;
    int gaps        = 0;
    int revoke_cyc  = -1;
    logic br_h1 = 1'b0, br_h2 = 1'b0, bg_prev = 1'b0, mw_prev = 1'b0;

    // Bus arbiter and memory: bg follows br one cycle later, ack arrives in
    // the second cycle of each write request. An armed revoke withholds the
    // grant (and the ack) for two cycles when the chosen address is written.
    logic        br_q = 1'b0;
    logic        wr_seen = 1'b0;
    int          hold = 0;
    logic        revoke_arm = 1'b0;
    logic [15:0] revoke_addr = '0;
    initial begin
        bg      = 1'b0;
        mem_ack = 1'b0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (revoke_arm && mem_write && !wr_seen && mem_addr == revoke_addr) begin
                revoke_arm = 1'b0;
                hold       = 2;
                revoke_cyc = cyc;
            end
            mem_ack = mem_write && wr_seen && !mem_ack && (hold == 0);
            bg      = (hold > 0) ? 1'b0 : br_q;
            if (hold > 0) hold--;
            br_q    = br;
            wr_seen = mem_write;
        end
    end

    // Monitor / scoreboard.
    always @(negedge clk) begin
        if (mem_write && mem_ack) begin
            n_writes++;
            if (exp_q.size() == 0) begin
                check("unexpected_write", 64'(mem_addr), 64'hFFFF_FFFF);
            end else begin
                wr_t w;
                w = exp_q.pop_front();
                check("write_addr", 64'(mem_addr), 64'(w.addr));
                check("write_data", mem_data, w.data);
            end
        end
        if (dma_end) begin
            n_end++;
            end_cyc = cyc;
        end
        if (br && !br_h1) begin
            n_br_rise++;
            if (br_rise_cyc < 0) br_rise_cyc = cyc;
        end
        if (bg && !bg_prev && bg_rise_cyc < 0) bg_rise_cyc = cyc;
        if (mem_write && !mw_prev) begin
            if (mw_first < 0) mw_first = cyc;
            else if (mw_second < 0) mw_second = cyc;
        end
        if (busy && br && !br_h1 && br_h2) gaps++;
        if (revoke_cyc >= 0 && cyc == revoke_cyc + 1) begin
            check("revoke_mem_write_low", 64'(mem_write), 64'd0);
            check("revoke_br_high", 64'(br), 64'd1);
        end
        br_h2   = br_h1;
        br_h1   = br;
        bg_prev = bg;
        mw_prev = mem_write;
    end

    task automatic clear_stamps();
        br_rise_cyc = -1;
        bg_rise_cyc = -1;
        mw_first    = -1;
        mw_second   = -1;
        gaps        = 0;
        end_cyc     = -1;
    endtask

    task automatic do_cmd(input logic [15:0] addr, input logic [15:0] len);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_addr  = addr;
        cmd_len   = len;
        cmd_cyc   = cyc;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_end(input string name, input int start);
        for (int k = 0; k < 200 && n_end == start; k++) @(negedge clk);
        if (n_end == start) check({name, "_timeout"}, 64'd0, 64'd1);
        repeat (3) @(negedge clk);
    endtask

    task automatic check_idle(input string name);
        check({name, "_busy"}, 64'(busy), 64'd0);
        check({name, "_br"}, 64'(br), 64'd0);
        check({name, "_offset"}, 64'(offset), 64'd0);
        check({name, "_mem_write"}, 64'(mem_write), 64'd0);
        check({name, "_dma_end"}, 64'(dma_end), 64'd0);
    endtask

    initial begin
        int w0, e0, b0;
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_addr  = '0;
        cmd_len   = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check_idle("reset");

        // 1: reset held two cycles in the middle of a write.
        do_cmd(16'h0100, 16'd12);
        for (int k = 0; k < 50 && !mem_write; k++) @(negedge clk);
        check("t1_reached_write", 64'(mem_write), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        check_idle("t1_in_reset");
        @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        check_idle("t1_after");
        check("t1_no_dma_end", 64'(n_end), 64'd0);
        check("t1_no_writes", 64'(n_writes), 64'd0);

        // 2: 12 words at 01F4, bg one cycle after br.
        clear_stamps();
        w0 = n_writes; e0 = n_end;
        push_expected(16'h01F4, 3);
        do_cmd(16'h01F4, 16'd12);
        wait_end("t2", e0);
        check("t2_writes", 64'(n_writes - w0), 64'd3);
        check("t2_dma_end_pulses", 64'(n_end - e0), 64'd1);
        check("t2_cmd_to_br", 64'(br_rise_cyc - cmd_cyc), 64'd1);
        check("t2_bg_to_mem_write", 64'(mw_first - bg_rise_cyc), 64'd2);
`ifdef DMA_CYCLE_STEAL_EN
        check("t2_br_gaps", 64'(gaps), 64'd2);
`else
        check("t2_line_cycles", 64'(mw_second - mw_first), 64'd3);
        check("t2_br_gaps", 64'(gaps), 64'd0);
`endif
        check("t2_queue_drained", 64'(exp_q.size()), 64'd0);
        check_idle("t2_after");

        // 3a: zero length -> no bus request, dma_end two cycles later.
        clear_stamps();
        w0 = n_writes; e0 = n_end; b0 = n_br_rise;
        do_cmd(16'h0300, 16'd0);
        wait_end("t3a", e0);
        check("t3a_end_latency", 64'(end_cyc - cmd_cyc), 64'd2);
        check("t3a_no_br", 64'(n_br_rise - b0), 64'd0);
        check("t3a_no_writes", 64'(n_writes - w0), 64'd0);

        // 3b: 5 words -> 2 lines; a command while busy is ignored.
        w0 = n_writes; e0 = n_end;
        push_expected(16'h0400, 2);
        do_cmd(16'h0400, 16'd5);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_addr = 16'h0800; cmd_len = 16'd4;
        @(negedge clk);
        cmd_valid = 1'b0;
        wait_end("t3b", e0);
        check("t3b_writes", 64'(n_writes - w0), 64'd2);
        check("t3b_dma_end_pulses", 64'(n_end - e0), 64'd1);

        // 3c/3d: 100 words and 16'hFFFF both clamp to 3 lines.
        w0 = n_writes; e0 = n_end;
        push_expected(16'h0500, 3);
        do_cmd(16'h0500, 16'd100);
        wait_end("t3c", e0);
        check("t3c_writes", 64'(n_writes - w0), 64'd3);
        w0 = n_writes; e0 = n_end;
        push_expected(16'h0600, 3);
        do_cmd(16'h0600, 16'hFFFF);
        wait_end("t3d", e0);
        check("t3d_writes", 64'(n_writes - w0), 64'd3);

        // 4: address wrap from FFFC to 0000.
        w0 = n_writes; e0 = n_end;
        push_expected(16'hFFFC, 2);
        do_cmd(16'hFFFC, 16'd8);
        wait_end("t4", e0);
        check("t4_writes", 64'(n_writes - w0), 64'd2);

        // 5: grant revoked during the write of line 1.
        w0 = n_writes; e0 = n_end;
        revoke_addr = 16'h0704;
        revoke_arm  = 1'b1;
        push_expected(16'h0700, 3);
        do_cmd(16'h0700, 16'd12);
        wait_end("t5", e0);
        check("t5_revoke_happened", 64'(revoke_cyc >= 0), 64'd1);
        check("t5_writes", 64'(n_writes - w0), 64'd3);
        check("t5_dma_end_pulses", 64'(n_end - e0), 64'd1);
        check("t5_queue_drained", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
